// File: rtl/ysyx_23060191_ifq.sv
// Instruction fetch queue: buffers {pc, inst} pairs between IFU and IDU, dropped on redirect, halts after ebreak.
// Latency: 1 cycle push-to-head when empty; head pc/inst are combinational reads of the read pointer.
// Backpressure: in_ready low when full, flushing or halted; out_valid low when empty, flushing or halted.
module ysyx_23060191_ifq #(
    parameter int               DEPTH  = 4,
    parameter int               XLEN   = 32,
    parameter logic [XLEN-1:0]  EBREAK = 32'h0010_0073
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] pc_mem_d   [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] inst_mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            halted_q, halted_d;
    logic            push, pop;

    // Handshakes and head read; flush and halt gate both sides so neither can complete.
    always_comb begin
        in_ready  = (count_q != CW'(DEPTH)) && !flush && !halted_q;
        out_valid = (count_q != '0) && !flush && !halted_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_pc    = pc_mem_q[rd_ptr_q];
        out_inst  = inst_mem_q[rd_ptr_q];
        count     = count_q;
        halted    = halted_q;
    end

    // Next-state: pointer/count movement, entry write, and sticky halt on consuming ebreak.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        halted_d   = halted_q;
        if (flush) begin
            // Redirect: entries are abandoned in place, only the bookkeeping is cleared.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]   = in_pc;
                inst_mem_d[wr_ptr_q] = in_inst;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if (out_inst == EBREAK) begin
                    halted_d = 1'b1;
                end
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset also zeroes storage so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_ifq.sv
module tb_ysyx_23060191_ifq;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] EBRK  = 32'h0010_0073;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        flush;
    logic [2:0]  count;
    logic        halted;

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];

    ysyx_23060191_ifq #(.DEPTH(4), .XLEN(32), .EBREAK(32'h0010_0073)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .flush     (flush),
        .count     (count),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one entry and record what should come out of the queue for it
    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        sb.push_back('{pc: pc, inst: inst});
    endtask

    // monitor: every completed pop is compared against the oldest expected entry
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc %h with nothing expected", out_pc);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (out_pc !== e.pc || out_inst !== e.inst) begin
                    errors++;
                    $display("FAIL pop_data: got pc %h inst %h expected pc %h inst %h",
                             out_pc, out_inst, e.pc, e.inst);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        out_ready = 1'b0; flush = 1'b0;
        #12;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_halted",    32'(halted),    32'd0);
        chk("rst_out_pc",    out_pc,         32'd0);
        chk("rst_out_inst",  out_inst,       32'd0);
        rstn = 1'b1;
        step();
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // fill to full with out_ready low
        for (int i = 0; i < 4; i++) begin
            drive(32'h8000_0000 + 32'(4 * i), NOP);
            step();
        end
        in_valid = 1'b1; in_pc = 32'h8000_0010; in_inst = NOP;
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_pc",   out_pc,        32'h8000_0000);
        step();
        chk("full_no_push_count", 32'(count), 32'd4);
        in_valid = 1'b0;

        // drain: four back-to-back pops in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            step();
        end
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        chk("drained_count",     32'(count),     32'd0);

        // streaming through pointer wrap: one in, one out per cycle
        for (int i = 0; i < 10; i++) begin
            drive(32'h8000_0000 + 32'(4 * i), 32'h0000_1000 + 32'(i));
            step();
            chk("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_count", 32'(count), 32'd0);
        chk("stream_sb_empty",  32'(sb.size()), 32'd0);

        // flush with concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h8000_0040 + 32'(4 * i), NOP);
            step();
        end
        in_valid = 1'b0;
        chk("pre_flush_count", 32'(count), 32'd3);
        in_valid = 1'b1; in_pc = 32'h8000_0100; in_inst = NOP; flush = 1'b1;
        #1;
        chk("flush_in_ready",  32'(in_ready),  32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("post_flush_count",     32'(count),     32'd0);
        chk("post_flush_out_valid", 32'(out_valid), 32'd0);
        drive(32'h8000_0200, NOP);
        step();
        in_valid = 1'b0;
        chk("after_flush_valid", 32'(out_valid), 32'd1);
        chk("after_flush_pc",    out_pc,         32'h8000_0200);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_flush_count", 32'(count), 32'd0);

        // ebreak halt
        drive(32'h8000_0300, NOP);  step();
        drive(32'h8000_0304, EBRK); step();
        drive(32'h8000_0308, NOP);  step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("pre_halt_halted", 32'(halted), 32'd0);
        step();
        chk("halt_halted",    32'(halted),    32'd1);
        chk("halt_out_valid", 32'(out_valid), 32'd0);
        chk("halt_in_ready",  32'(in_ready),  32'd0);
        chk("halt_count",     32'(count),     32'd1);
        in_valid = 1'b1; in_pc = 32'h8000_0400; in_inst = NOP;
        step();
        in_valid = 1'b0;
        chk("halt_no_push_count", 32'(count), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("halt_survives_flush", 32'(halted), 32'd1);
        out_ready = 1'b0;
        sb.delete();

        // reset clears halt
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        step();
        chk("rst_clears_halted", 32'(halted), 32'd0);

        // async reset mid-stream with two entries buffered
        drive(32'h8000_0500, NOP); step();
        drive(32'h8000_0504, NOP); step();
        in_valid = 1'b0;
        chk("pre_arst_count", 32'(count), 32'd2);
        #1;
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_halted",    32'(halted),    32'd0);
        chk("arst_out_pc",    out_pc,         32'd0);
        step();
        rstn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_ifq.md
# ysyx_23060191_ifq

Instruction fetch queue between the IFU and the IDU inside `ysyx_23060191_CPU`. It buffers up to DEPTH fetched {pc, inst} pairs so fetch and decode run decoupled with valid/ready handshakes on both sides. It discards all buffered entries on a control-flow redirect (JAL/JALR or branch flush). It raises a sticky halt when an `ebreak` instruction is handed to decode.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, pc and instruction width (`CPU_WIDTH`)
- EBREAK, 32'h0010_0073, encoding that triggers halt

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- in_valid  input  1  IFU presents a fetched instruction
- in_ready  output  1  queue accepts the IFU entry this cycle
- in_pc  input  XLEN  pc of the fetched instruction
- in_inst  input  XLEN  fetched instruction word
- out_valid  output  1  head entry available to IDU
- out_ready  input  1  IDU consumes the head entry this cycle
- out_pc  output  XLEN  pc of the head entry
- out_inst  output  XLEN  instruction of the head entry
- flush  input  1  redirect; discard all entries (driven by jump_en from IDU/EXU)
- count  output  $clog2(DEPTH+1)  number of valid entries
- halted  output  1  sticky; an EBREAK entry has been consumed

## Operation
- Storage: circular array of DEPTH {pc, inst} entries. Read pointer and write pointer are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. The occupancy counter is separate.
- Push: `in_valid && in_ready`. Writes mem[wr_ptr] and increments wr_ptr.
- Pop: `out_valid && out_ready`. Increments rd_ptr.
- count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `in_ready = (count != DEPTH) && !flush && !halted`.
  - No push while full, even if a pop occurs the same cycle.
- `out_valid = (count != 0) && !flush && !halted`.
- out_pc and out_inst are combinational reads of mem[rd_ptr] (first-word fall-through). They are meaningful only while out_valid is high.
- Flush: synchronous. At the edge where flush=1:
  - rd_ptr, wr_ptr and count go to 0.
  - No push or pop takes effect that cycle, since in_ready and out_valid are forced low.
  - Memory contents are not cleared.
- Halt: at a pop edge where out_inst == EBREAK, halted is set to 1.
  - The EBREAK entry is consumed.
  - From then on no push or pop occurs; out_valid and in_ready stay 0.
  - flush does not clear halted. Only rstn clears it.
- Reset (rstn=0, asynchronous) sets:
  - rd_ptr, wr_ptr and count to 0
  - halted to 0
  - all mem entries to 0, so out_pc and out_inst read 0
  - out_valid=0 and in_ready=1, both holding through the first edge after release

## Timing
- Push-to-output latency is 1 cycle: an entry pushed at edge N is visible with out_valid=1 after edge N, when the queue was empty.
- There is no combinational path from in_valid to out_valid.
- in_ready depends only on registered state and flush. It has no path from out_ready.
- Full queue with out_ready=1: one entry pops at edge N. in_ready rises after edge N, and the next push lands at edge N+1.
- flush asserted together with in_valid or out_ready: the flush wins, and neither handshake completes.
- Reset asserted mid-operation: the queue empties immediately, without waiting for clk.
- Sustained throughput is one entry per cycle when 0 < count < DEPTH and both sides are valid/ready.

## Test plan
- Reset and fill:
  - Release rstn.
  - Push 4 entries: pc 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C; inst 0x0000_0013 (nop), out_ready=0.
  - Required: count=4, in_ready=0, out_pc=0x8000_0000.
  - A 5th in_valid is not accepted, and count stays 4.
- Drain order:
  - From full, hold out_ready=1.
  - Required: out_pc sequences 0x8000_0000…0x8000_000C on 4 consecutive cycles.
  - Then out_valid=0 and count=0.
- Wrap-around streaming:
  - Hold in_valid=1 and out_ready=1 for 10 cycles, pc incrementing by 4 from 0x8000_0000.
  - Required: the outputs match the inputs in order, delayed 1 cycle, and count stays at 1.
- Flush with concurrent push:
  - With count=3, assert flush for 1 cycle with in_valid=1 (pc 0x8000_0100).
  - Required: count=0 and out_valid=0 next cycle.
  - A following push of 0x8000_0200 appears as out_pc=0x8000_0200 one cycle later.
- Ebreak halt:
  - Queue nop, 0x0010_0073, nop with out_ready=1.
  - Required: halted=1 after the edge that pops 0x0010_0073.
  - out_valid=0, in_ready=0 and count=1 thereafter.
  - A flush leaves halted=1.
- Async reset mid-stream:
  - Drop rstn between edges with count=2.
  - Required: count=0, out_valid=0, halted=0 and out_pc=0 before the next rising clk.
